rptr_ctrl: RTL and testbench
============================

RPTR_CTRL -- requirements
Module: rptr_ctrl

Interface
REQ-001 SHALL have parameter PTR_WIDTH, default 3, address bits; FIFO depth is 2**PTR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, word width.
REQ-003 SHALL have parameter AE_THRESH, default 1, almost-empty threshold in words (0..2**PTR_WIDTH).
REQ-004 SHALL have parameter FWFT, default 0; 0 selects standard read mode, 1 selects first-word-fall-through mode.
REQ-005 SHALL have port rclk, input, 1, the only clock; all logic is on its rising edge.
REQ-006 SHALL have port rrst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port r_en, input, 1, read request or pop.
REQ-008 SHALL have port g_wptr_sync, input, PTR_WIDTH+1, Gray write pointer, already synchronised into rclk.
REQ-009 SHALL have port mem_rdata, input, DATA_WIDTH, RAM read data; valid 1 cycle after mem_ren and held while mem_ren=0.
REQ-010 SHALL have port mem_ren, output, 1, RAM read enable (combinational).
REQ-011 SHALL have port raddr, output, PTR_WIDTH, RAM read address = b_rptr[PTR_WIDTH-1:0].
REQ-012 SHALL have ports b_rptr and g_rptr, output, PTR_WIDTH+1 each, binary and Gray read pointer.
REQ-013 SHALL have port rdata, output, DATA_WIDTH, equal to mem_rdata.
REQ-014 SHALL have port rvalid, output, 1, rdata holds a valid word.
REQ-015 SHALL have ports empty and almost_empty, output, 1 each, status flags.
REQ-016 SHALL have port rlevel, output, PTR_WIDTH+1, words in RAM not yet read.
REQ-017 SHALL have port underflow, output, 1, sticky read-while-empty flag.

Function
REQ-018 SHALL compute b_rptr_next = b_rptr + mem_ren modulo 2**(PTR_WIDTH+1) and g_rptr_next = (b_rptr_next>>1) XOR b_rptr_next, both registered each cycle.
REQ-019 SHALL register mem_empty = (g_wptr_sync == g_rptr_next).
REQ-020 SHALL register rlevel = gray2bin(g_wptr_sync) - b_rptr_next, modulo 2**(PTR_WIDTH+1).
REQ-021 SHALL register almost_empty = (level_next <= AE_THRESH), where level_next is the value rlevel takes at the same edge.
REQ-022 SHALL, when FWFT=0, drive mem_ren = r_en AND NOT mem_empty, drive empty = mem_empty, and pulse rvalid for exactly the cycle after each mem_ren.
REQ-023 SHALL, when FWFT=1, run FSM IDLE/VALID, with rvalid=1 exactly in VALID and empty = NOT rvalid.
REQ-024 SHALL, when FWFT=1 in IDLE with mem_empty=0, drive mem_ren=1 and go to VALID; otherwise remain in IDLE.
REQ-025 SHALL, when FWFT=1 in VALID with r_en=1 and mem_empty=0, drive mem_ren=1 and stay in VALID; back-to-back pops give one word per cycle.
REQ-026 SHALL, when FWFT=1 in VALID with r_en=1 and mem_empty=1, go to IDLE; with r_en=0 it SHALL hold state and drive mem_ren=0.
REQ-027 SHALL, when FWFT=1, ignore r_en in IDLE.
REQ-028 SHALL set underflow when r_en=1 with no data available (FWFT=0: empty=1; FWFT=1: rvalid=0); underflow stays set until reset, and the pointer does not move.
REQ-029 SHALL handle pointer wrap from 2**(PTR_WIDTH+1)-1 to 0 seamlessly; rlevel stays correct across the wrap.
REQ-030 SHALL, when a write arrives in the same cycle as the last read, take mem_empty and rlevel from g_wptr_sync sampled that cycle; there is no lost or double-counted word.

Reset
REQ-031 SHALL, while rrst=1 (asynchronously), set b_rptr=0, g_rptr=0, empty=1, almost_empty=1, rlevel=0, rvalid=0, underflow=0, FSM=IDLE, and mem_ren=0.
REQ-032 SHALL discard any pending RAM read on reset mid-operation; the first operation after rrst deasserts starts from pointer 0.

Structure
REQ-033 SHALL place FSM state encodings (IDLE=0, VALID=1) and the Gray-to-binary width rule in the shared async-FIFO package or include.
REQ-034 SHALL implement gray2bin as a sub-module, parameterised by width, instantiated once for g_wptr_sync.

Verification
REQ-035 SHALL cover: FWFT=0, PTR_WIDTH=3, 3 writes then r_en held for 4 cycles -> 3 mem_ren, rvalid pulses at cycles 2-4, empty=1 after the third read, underflow=1 on the fourth.
REQ-036 SHALL cover: FWFT=1, g_wptr_sync moves 0->1 -> mem_ren next cycle, rvalid=1 one cycle later with rdata=word0, and it holds while r_en=0.
REQ-037 SHALL cover: FWFT=1, 8 words, r_en held -> 8 consecutive rvalid cycles, then IDLE, empty=1, underflow=0.
REQ-038 SHALL cover: 20 write/read iterations with PTR_WIDTH=3 -> pointers wrap past 15, Gray sequence checked each step, rlevel always equals the model.
REQ-039 SHALL cover: AE_THRESH=2 with levels 4->3->2->1 -> almost_empty rises when rlevel reaches 2.
REQ-040 SHALL cover: rrst pulsed with rvalid=1 and level 5 -> all outputs take their reset values in the same cycle and the FSM is IDLE.

Source files
------------

// File: rtl/rptr_ctrl_pkg.sv
// Shared definitions for the async-FIFO read side: FSM state encoding and
// the Gray-to-binary width rule.
package rptr_ctrl_pkg;

  // FWFT output-stage states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } rd_state_e;

  // A Gray code converts to a binary value of the same width
  function automatic int unsigned g2b_width(input int unsigned gray_w);
    return gray_w;
  endfunction

endpackage

// File: rtl/rptr_ctrl_gray2bin.sv
// Width-parameterised Gray-to-binary converter (pure combinational).
module rptr_ctrl_gray2bin
  import rptr_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]                i_gray,
  output logic [g2b_width(W)-1:0]     o_bin
);

  // Each binary bit is the XOR of all Gray bits at or above its position
  always_comb begin
    o_bin = '0;
    for (int i = 0; i < W; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/rptr_ctrl.sv
// Read-side pointer controller of an asynchronous FIFO. Keeps the binary and
// Gray read pointers, derives empty / almost-empty / level from the already
// synchronised Gray write pointer, and drives the RAM read port in either
// standard or first-word-fall-through mode.
module rptr_ctrl
  import rptr_ctrl_pkg::*;
#(
  parameter int PTR_WIDTH  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  r_en,
  input  logic [PTR_WIDTH:0]    g_wptr_sync,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ren,
  output logic [PTR_WIDTH-1:0]  raddr,
  output logic [PTR_WIDTH:0]    b_rptr,
  output logic [PTR_WIDTH:0]    g_rptr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    rlevel,
  output logic                  underflow
);

  localparam int AW = PTR_WIDTH + 1;
  localparam logic [AW:0] AE_VAL = AE_THRESH[AW:0];

  logic [AW-1:0] r_b_rptr;
  logic [AW-1:0] r_g_rptr;
  logic [AW-1:0] r_rlevel;
  logic          r_mem_empty;
  logic          r_almost_empty;
  logic          r_underflow;

  logic [AW-1:0] w_b_rptr_next;
  logic [AW-1:0] w_g_rptr_next;
  logic [AW-1:0] w_wptr_bin;
  logic [AW-1:0] w_level_next;
  logic          w_mem_ren;
  logic          w_rvalid;
  logic          w_empty;
  logic          w_no_data;

  rptr_ctrl_gray2bin #(.W(AW)) u_wptr_g2b (
    .i_gray (g_wptr_sync),
    .o_bin  (w_wptr_bin)
  );

  assign w_b_rptr_next = r_b_rptr + {{PTR_WIDTH{1'b0}}, w_mem_ren};
  assign w_g_rptr_next = (w_b_rptr_next >> 1) ^ w_b_rptr_next;
  assign w_level_next  = w_wptr_bin - w_b_rptr_next;

  // Pointer, status-flag and sticky underflow registers
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_b_rptr       <= '0;
      r_g_rptr       <= '0;
      r_rlevel       <= '0;
      r_mem_empty    <= 1'b1;
      r_almost_empty <= 1'b1;
      r_underflow    <= 1'b0;
    end else begin
      r_b_rptr       <= w_b_rptr_next;
      r_g_rptr       <= w_g_rptr_next;
      r_rlevel       <= w_level_next;
      r_mem_empty    <= (g_wptr_sync == w_g_rptr_next);
      r_almost_empty <= ({1'b0, w_level_next} <= AE_VAL);
      r_underflow    <= r_underflow | (r_en & w_no_data);
    end
  end

  if (FWFT == 0) begin : g_std
    logic r_rvalid;

    assign w_mem_ren = r_en & ~r_mem_empty;
    assign w_empty   = r_mem_empty;
    assign w_no_data = r_mem_empty;
    assign w_rvalid  = r_rvalid;

    // Read data arrives one cycle after the RAM read enable
    always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= w_mem_ren;
      end
    end
  end else begin : g_fwft
    rd_state_e r_state;
    rd_state_e w_state_next;
    logic      w_fetch;

    // FWFT state register
    always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
        r_state <= ST_IDLE;
      end else begin
        r_state <= w_state_next;
      end
    end

    // FWFT next-state: prefetch when idle, refill or drain on a pop
    always_comb begin
      w_state_next = r_state;
      case (r_state)
        ST_IDLE: begin
          if (!r_mem_empty) w_state_next = ST_VALID;
          else              w_state_next = ST_IDLE;
        end
        ST_VALID: begin
          if (r_en && r_mem_empty) w_state_next = ST_IDLE;
          else                     w_state_next = ST_VALID;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end

    // FWFT outputs: RAM read enable for prefetch and refill
    always_comb begin
      w_fetch = 1'b0;
      case (r_state)
        ST_IDLE:  w_fetch = ~r_mem_empty;
        ST_VALID: w_fetch = r_en & ~r_mem_empty;
        default:  w_fetch = 1'b0;
      endcase
    end

    assign w_mem_ren = w_fetch;
    assign w_rvalid  = (r_state == ST_VALID);
    assign w_empty   = ~w_rvalid;
    assign w_no_data = ~w_rvalid;
  end

  assign mem_ren      = w_mem_ren;
  assign raddr        = r_b_rptr[PTR_WIDTH-1:0];
  assign b_rptr       = r_b_rptr;
  assign g_rptr       = r_g_rptr;
  assign rdata        = mem_rdata;
  assign rvalid       = w_rvalid;
  assign empty        = w_empty;
  assign almost_empty = r_almost_empty;
  assign rlevel       = r_rlevel;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_rptr_ctrl.sv
// Bench for rptr_ctrl: a standard-mode instance (AE_THRESH=2) and a FWFT
// instance (AE_THRESH=1) share one write stream and one r_en, each with its
// own RAM read port, and are compared every cycle against a word-count and
// queue based model.
module tb_rptr_ctrl;

  localparam int PW = 3;
  localparam int DW = 8;
  localparam int AW = PW + 1;
  localparam int S_AE = 2;
  localparam int F_AE = 1;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          r_en;
  logic [AW-1:0] g_wptr_sync;

  logic [DW-1:0] s_mem_rdata, f_mem_rdata;
  logic          s_mem_ren, f_mem_ren;
  logic [PW-1:0] s_raddr, f_raddr;
  logic [AW-1:0] s_b_rptr, f_b_rptr, s_g_rptr, f_g_rptr, s_rlevel, f_rlevel;
  logic [DW-1:0] s_rdata, f_rdata;
  logic          s_rvalid, f_rvalid, s_empty, f_empty, s_ae, f_ae, s_uf, f_uf;

  int checks = 0;
  int errors = 0;

  rptr_ctrl #(.PTR_WIDTH(PW), .DATA_WIDTH(DW), .AE_THRESH(S_AE), .FWFT(0)) u_std (
    .rclk(rclk), .rrst(rrst), .r_en(r_en), .g_wptr_sync(g_wptr_sync),
    .mem_rdata(s_mem_rdata), .mem_ren(s_mem_ren), .raddr(s_raddr),
    .b_rptr(s_b_rptr), .g_rptr(s_g_rptr), .rdata(s_rdata), .rvalid(s_rvalid),
    .empty(s_empty), .almost_empty(s_ae), .rlevel(s_rlevel), .underflow(s_uf)
  );

  rptr_ctrl #(.PTR_WIDTH(PW), .DATA_WIDTH(DW), .AE_THRESH(F_AE), .FWFT(1)) u_fw (
    .rclk(rclk), .rrst(rrst), .r_en(r_en), .g_wptr_sync(g_wptr_sync),
    .mem_rdata(f_mem_rdata), .mem_ren(f_mem_ren), .raddr(f_raddr),
    .b_rptr(f_b_rptr), .g_rptr(f_g_rptr), .rdata(f_rdata), .rvalid(f_rvalid),
    .empty(f_empty), .almost_empty(f_ae), .rlevel(f_rlevel), .underflow(f_uf)
  );

  always #5 rclk = ~rclk;

  // Shared RAM contents, one synchronous read port per DUT
  logic [DW-1:0] ram [8];
  initial begin
    s_mem_rdata = '0;
    f_mem_rdata = '0;
  end
  always @(posedge rclk) if (s_mem_ren) s_mem_rdata <= ram[s_raddr];
  always @(posedge rclk) if (f_mem_ren) f_mem_rdata <= ram[f_raddr];

  // Model: total words written, write count visible to the DUTs (sampled
  // at the last edge), words each DUT has taken out of RAM, queued data.
  int            wr_total, wr_seen, s_rd, f_rd;
  bit            s_rv_m, f_rv_m, s_uf_m, f_uf_m;
  logic [DW-1:0] s_head, f_head, last_wdata;
  logic [DW-1:0] s_q[$];
  logic [DW-1:0] f_q[$];
  logic          last_s_ren;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] to_gray(input int v);
    logic [AW-1:0] b;
    b = v[AW-1:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int s_lvl();
    return wr_seen - s_rd;
  endfunction

  function automatic int f_lvl();
    return wr_seen - f_rd;
  endfunction

  // Standard mode: a read happens only when a word is visible
  function automatic bit s_pop(input bit rd);
    return rd && (s_lvl() != 0);
  endfunction

  // FWFT: fetch whenever the output slot is free or being consumed
  function automatic bit f_pop(input bit rd);
    bit consumed;
    consumed = f_rv_m && rd;
    return (!f_rv_m || consumed) && (f_lvl() != 0);
  endfunction

  task automatic check_outputs(input bit rd);
    check("s_mem_ren", 32'(s_mem_ren), 32'(s_pop(rd)));
    check("s_b_rptr", 32'(s_b_rptr), s_rd % 16);
    check("s_g_rptr", 32'(s_g_rptr), 32'(to_gray(s_rd)));
    check("s_raddr", 32'(s_raddr), s_rd % 8);
    check("s_rlevel", 32'(s_rlevel), s_lvl());
    check("s_empty", 32'(s_empty), 32'(s_lvl() == 0));
    check("s_almost_empty", 32'(s_ae), 32'(s_lvl() <= S_AE));
    check("s_rvalid", 32'(s_rvalid), 32'(s_rv_m));
    check("s_underflow", 32'(s_uf), 32'(s_uf_m));
    if (s_rv_m) check("s_rdata", 32'(s_rdata), 32'(s_head));
    check("f_mem_ren", 32'(f_mem_ren), 32'(f_pop(rd)));
    check("f_b_rptr", 32'(f_b_rptr), f_rd % 16);
    check("f_g_rptr", 32'(f_g_rptr), 32'(to_gray(f_rd)));
    check("f_rlevel", 32'(f_rlevel), f_lvl());
    check("f_empty", 32'(f_empty), 32'(!f_rv_m));
    check("f_almost_empty", 32'(f_ae), 32'(f_lvl() <= F_AE));
    check("f_rvalid", 32'(f_rvalid), 32'(f_rv_m));
    check("f_underflow", 32'(f_uf), 32'(f_uf_m));
    if (f_rv_m) check("f_rdata", 32'(f_rdata), 32'(f_head));
  endtask

  // One clock cycle: drive inputs just after an edge, check mid-cycle,
  // advance the model across the next edge.
  task automatic step(input bit rd, input bit wr);
    bit sp, fp, consumed;
    int min_rd;
    r_en = rd;
    min_rd = (s_rd < f_rd) ? s_rd : f_rd;
    if (wr && (wr_total - min_rd < 8)) begin
      last_wdata = DW'($urandom);
      ram[wr_total % 8] = last_wdata;
      s_q.push_back(last_wdata);
      f_q.push_back(last_wdata);
      wr_total++;
      g_wptr_sync = to_gray(wr_total);
    end
    @(negedge rclk);
    check_outputs(rd);
    last_s_ren = s_mem_ren;
    sp = s_pop(rd);
    fp = f_pop(rd);
    @(posedge rclk);
    #1;
    if (rd && s_lvl() == 0) s_uf_m = 1'b1;
    if (rd && !f_rv_m) f_uf_m = 1'b1;
    s_rv_m = sp;
    if (sp) s_head = s_q.pop_front();
    consumed = f_rv_m && rd;
    f_rv_m = fp || (f_rv_m && !consumed);
    if (fp) f_head = f_q.pop_front();
    s_rd += int'(sp);
    f_rd += int'(fp);
    wr_seen = wr_total;
  endtask

  task automatic reset_checks();
    check("rst_s_b_rptr", 32'(s_b_rptr), 32'd0);
    check("rst_s_g_rptr", 32'(s_g_rptr), 32'd0);
    check("rst_s_empty", 32'(s_empty), 32'd1);
    check("rst_s_ae", 32'(s_ae), 32'd1);
    check("rst_s_rlevel", 32'(s_rlevel), 32'd0);
    check("rst_s_rvalid", 32'(s_rvalid), 32'd0);
    check("rst_s_underflow", 32'(s_uf), 32'd0);
    check("rst_s_mem_ren", 32'(s_mem_ren), 32'd0);
    check("rst_f_b_rptr", 32'(f_b_rptr), 32'd0);
    check("rst_f_g_rptr", 32'(f_g_rptr), 32'd0);
    check("rst_f_empty", 32'(f_empty), 32'd1);
    check("rst_f_ae", 32'(f_ae), 32'd1);
    check("rst_f_rlevel", 32'(f_rlevel), 32'd0);
    check("rst_f_rvalid", 32'(f_rvalid), 32'd0);
    check("rst_f_underflow", 32'(f_uf), 32'd0);
    check("rst_f_mem_ren", 32'(f_mem_ren), 32'd0);
  endtask

  task automatic clear_model();
    wr_total = 0; wr_seen = 0; s_rd = 0; f_rd = 0;
    s_rv_m = 1'b0; f_rv_m = 1'b0; s_uf_m = 1'b0; f_uf_m = 1'b0;
    s_head = '0; f_head = '0;
    s_q.delete(); f_q.delete();
    g_wptr_sync = '0;
    r_en = 1'b0;
  endtask

  // Asynchronous reset pulse mid-cycle; outputs checked before any edge
  task automatic do_reset();
    #2;
    rrst = 1'b1;
    clear_model();
    #1;
    reset_checks();
    @(posedge rclk);
    #1;
    rrst = 1'b0;
  endtask

  initial begin
    int cnt;
    rrst = 1'b1;
    last_wdata = '0;
    last_s_ren = 1'b0;
    clear_model();
    for (int i = 0; i < 8; i++) ram[i] = '0;
    repeat (2) @(posedge rclk);
    #1;
    reset_checks();
    rrst = 1'b0;

    // Standard mode: 3 words then r_en held 4 cycles
    repeat (3) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      cnt += int'(last_s_ren);
    end
    check("std_ren_count", 32'(cnt), 32'd3);
    check("std_empty_after", 32'(s_empty), 32'd1);
    check("std_underflow", 32'(s_uf), 32'd1);

    // FWFT: first word falls through and holds while r_en=0
    do_reset();
    step(1'b0, 1'b1);
    check("fw_prefetch_ren", 32'(f_mem_ren), 32'd1);
    step(1'b0, 1'b0);
    check("fw_first_valid", 32'(f_rvalid), 32'd1);
    check("fw_first_data", 32'(f_rdata), 32'(last_wdata));
    repeat (2) step(1'b0, 1'b0);
    check("fw_hold_valid", 32'(f_rvalid), 32'd1);
    check("fw_hold_data", 32'(f_rdata), 32'(last_wdata));

    // FWFT: 8 words drained back to back
    do_reset();
    repeat (8) step(1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cnt += int'(f_rvalid);
      step(1'b1, 1'b0);
    end
    check("fw_burst_valid_count", 32'(cnt), 32'd8);
    step(1'b0, 1'b0);
    check("fw_burst_empty", 32'(f_empty), 32'd1);
    check("fw_burst_rvalid", 32'(f_rvalid), 32'd0);
    check("fw_burst_underflow", 32'(f_uf), 32'd0);

    // Standard mode almost-empty threshold 2 with levels 4,3,2,1
    do_reset();
    repeat (4) step(1'b0, 1'b1);
    check("ae_lvl4", 32'(s_rlevel), 32'd4);
    check("ae_at4", 32'(s_ae), 32'd0);
    step(1'b1, 1'b0);
    check("ae_at3", 32'(s_ae), 32'd0);
    step(1'b1, 1'b0);
    check("ae_lvl2", 32'(s_rlevel), 32'd2);
    check("ae_at2", 32'(s_ae), 32'd1);
    step(1'b1, 1'b0);
    check("ae_at1", 32'(s_ae), 32'd1);

    // Reset with FWFT holding a word and 5 more in RAM
    do_reset();
    repeat (6) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("pre_rst_f_level", 32'(f_rlevel), 32'd5);
    check("pre_rst_f_rvalid", 32'(f_rvalid), 32'd1);
    do_reset();
    step(1'b0, 1'b0);

    // Random traffic, wrapping the pointers many times
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
    end
    step(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
